// File: rtl/serial_word_rx_pkg.sv
// Shared definitions for the 4-bit serial link: default word/FIFO sizes,
// shift direction encodings (common with the transmitter shift register)
// and the transmitter's MODO mode encodings.
package serial_word_rx_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int DEPTH_DEF = 2;

    // Shift direction, as seen on DIR at both ends of the link.
    localparam logic DIR_LEFT  = 1'b0;  // MSB first
    localparam logic DIR_RIGHT = 1'b1;  // LSB first

    // Transmitter shift-register operating modes.
    typedef enum logic [1:0] {
        MODO_HOLD  = 2'b00,
        MODO_LOAD  = 2'b01,
        MODO_SHL   = 2'b10,
        MODO_SHR   = 2'b11
    } modo_e;

endpackage

// File: rtl/serial_word_rx_if.sv
// Receiver-side bundle: serial intake controls, consumer handshake and
// status outputs.
//   master : drives enb/s_in/dir/sync/rdy/clr_ovr, observes q/valid/busy/level/overrun
//   slave  : the receiver itself
interface serial_word_rx_if #(
    parameter int WIDTH = 4,
    parameter int LVLW  = 2
);
    logic             enb;
    logic             s_in;
    logic             dir;
    logic             sync;
    logic             rdy;
    logic             clr_ovr;
    logic [WIDTH-1:0] q;
    logic             valid;
    logic             busy;
    logic [LVLW-1:0]  level;
    logic             overrun;

    modport master (
        output enb, s_in, dir, sync, rdy, clr_ovr,
        input  q, valid, busy, level, overrun
    );

    modport slave (
        input  enb, s_in, dir, sync, rdy, clr_ovr,
        output q, valid, busy, level, overrun
    );
endinterface

// File: rtl/serial_word_rx_fifo.sv
// word_fifo: small synchronous FIFO holding completed words.
// Ports: i_clk, i_rst_n (async active low), i_push/i_data, i_pop,
//        o_data (head word, 0 when empty), o_valid, o_level, o_drop
//        (push refused because full with no simultaneous pop).
module word_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int LVLW  = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [LVLW-1:0]  o_level,
    output logic             o_drop
);
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTRW-1:0]  r_rd, r_wr;
    logic [LVLW-1:0]  r_cnt;

    logic w_empty, w_full, w_pop, w_wr;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == LVLW'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign w_wr    = i_push && (!w_full || w_pop);
    assign o_drop  = i_push && !w_wr;

    assign o_valid = !w_empty;
    assign o_level = r_cnt;
    assign o_data  = w_empty ? '0 : r_mem[r_rd];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr] <= i_data;
                r_wr <= (r_wr == PTRW'(DEPTH-1)) ? '0 : r_wr + 1'b1;
            end
            if (w_pop)
                r_rd <= (r_rd == PTRW'(DEPTH-1)) ? '0 : r_rd + 1'b1;
            if (w_wr && !w_pop)
                r_cnt <= r_cnt + 1'b1;
            else if (w_pop && !w_wr)
                r_cnt <= r_cnt - 1'b1;
        end
    end
endmodule

// File: rtl/serial_word_rx.sv
// serial_word_rx: deserializes the S_OUT stream of the shift-register link
// into WIDTH-bit words and queues them for a valid/ready consumer.
// Ports: i_clk, i_rst_n (async active low), bus (serial_word_rx_if.slave):
//   enb/s_in/dir/sync  bit intake, rdy consumer handshake, clr_ovr,
//   q/valid/level      FIFO head and occupancy, busy partial frame,
//   overrun            sticky word-dropped flag.
module serial_word_rx
    import serial_word_rx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int LVLW  = $clog2(DEPTH + 1)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    serial_word_rx_if.slave bus
);
    localparam int CNTW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] r_acc;
    logic [CNTW-1:0]  r_cnt;
    logic             r_dir;
    logic             r_ovr;

    logic             w_first, w_last, w_dir, w_push, w_drop;
    logic [WIDTH-1:0] w_base, w_acc_nxt;

    // SYNC forces the current bit to be bit 0 of a fresh frame.
    assign w_first = bus.sync || (r_cnt == '0);
    assign w_last  = (r_cnt == CNTW'(WIDTH-1));
    assign w_dir   = w_first ? bus.dir : r_dir;
    assign w_base  = bus.sync ? '0 : r_acc;

    always_comb begin
        w_acc_nxt = {w_base[WIDTH-2:0], bus.s_in};
        if (w_dir == DIR_RIGHT)
            w_acc_nxt = {bus.s_in, w_base[WIDTH-1:1]};
    end

    // A SYNC bit always leaves count at 1, so it can never complete a word.
    assign w_push = bus.enb && !bus.sync && w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_dir <= DIR_LEFT;
        end else if (bus.enb) begin
            r_acc <= w_acc_nxt;
            r_dir <= w_dir;
            if (bus.sync)
                r_cnt <= CNTW'(1);
            else if (w_last)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end else if (bus.sync) begin
            r_acc <= '0;
            r_cnt <= '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_ovr <= 1'b0;
        else if (w_drop)
            r_ovr <= 1'b1;
        else if (bus.clr_ovr)
            r_ovr <= 1'b0;
    end

    word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .LVLW  (LVLW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (w_acc_nxt),
        .i_pop   (bus.rdy),
        .o_data  (bus.q),
        .o_valid (bus.valid),
        .o_level (bus.level),
        .o_drop  (w_drop)
    );

    assign bus.busy    = (r_cnt != '0);
    assign bus.overrun = r_ovr;
endmodule

// File: tb/tb_serial_word_rx.sv
module tb_serial_word_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_word_rx_if #(.WIDTH(4), .LVLW(2)) bus ();

    serial_word_rx #(.WIDTH(4), .DEPTH(2), .LVLW(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    int n_pass = 0;
    int n_tot  = 0;
    logic [3:0] exp_q [$];

    typedef struct {
        logic       dir0;   // DIR on the first (SYNC) bit
        logic       dirr;   // DIR on the remaining bits
        logic [3:0] bits;   // bits[3] sent first
        logic [3:0] expq;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tot++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    // Scoreboard: every pop is compared against the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && bus.valid && bus.rdy) begin
            n_tot++;
            if (exp_q.size() == 0) begin
                $display("FAIL pop_unexpected: got %0h expected none", bus.q);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (bus.q === e) n_pass++;
                else $display("FAIL pop_data: got %0h expected %0h", bus.q, e);
            end
        end
    end

    // Inputs change 1 time unit after the rising edge.
    task automatic send_bit(input logic b, input logic d, input logic s);
        bus.enb = 1'b1; bus.s_in = b; bus.dir = d; bus.sync = s;
        @(posedge clk); #1;
        bus.enb = 1'b0; bus.sync = 1'b0; bus.s_in = 1'b0;
    endtask

    task automatic send_msb(input logic [3:0] w, input logic rdy_last);
        send_bit(w[3], 1'b0, 1'b1);
        send_bit(w[2], 1'b0, 1'b0);
        send_bit(w[1], 1'b0, 1'b0);
        bus.rdy = rdy_last;
        send_bit(w[0], 1'b0, 1'b0);
        bus.rdy = 1'b0;
    endtask

    task automatic pop_n(input int n);
        bus.rdy = 1'b1;
        repeat (n) @(posedge clk);
        #1 bus.rdy = 1'b0;
    endtask

    initial begin
        bus.enb = 0; bus.s_in = 0; bus.dir = 0; bus.sync = 0;
        bus.rdy = 0; bus.clr_ovr = 0;
        vecs[0] = '{1'b0, 1'b0, 4'b1011, 4'hB};
        vecs[1] = '{1'b1, 1'b1, 4'b1011, 4'hD};
        vecs[2] = '{1'b1, 1'b0, 4'b1011, 4'hD};  // DIR toggles after bit 0
        vecs[3] = '{1'b0, 1'b1, 4'b0101, 4'h5};
        vecs[4] = '{1'b1, 1'b1, 4'b0001, 4'h8};
        vecs[5] = '{1'b0, 1'b0, 4'b1000, 4'h8};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", bus.valid, 0);
        chk("rst_q", bus.q, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ovr", bus.overrun, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven single frames
        foreach (vecs[i]) begin
            send_bit(vecs[i].bits[3], vecs[i].dir0, 1'b1);
            chk("frm_busy_mid", bus.busy, 1);
            for (int k = 2; k >= 0; k--) send_bit(vecs[i].bits[k], vecs[i].dirr, 1'b0);
            chk("frm_valid", bus.valid, 1);
            chk("frm_q", bus.q, vecs[i].expq);
            chk("frm_level", bus.level, 1);
            chk("frm_busy", bus.busy, 0);
            exp_q.push_back(vecs[i].expq);
            pop_n(1);
            chk("frm_level_after_pop", bus.level, 0);
        end

        // SYNC resync discards a 2-bit partial frame
        send_bit(1, 0, 1);
        send_bit(1, 0, 0);
        chk("sync_busy", bus.busy, 1);
        send_bit(0, 0, 1);
        send_bit(1, 0, 0);
        send_bit(0, 0, 0);
        chk("sync_no_early_word", bus.valid, 0);
        send_bit(1, 0, 0);
        chk("sync_q", bus.q, 4'h5);
        chk("sync_level", bus.level, 1);
        exp_q.push_back(4'h5);
        pop_n(1);
        chk("sync_one_word", bus.level, 0);

        // SYNC without ENB clears a partial frame
        send_bit(1, 0, 1);
        bus.sync = 1'b1; @(posedge clk); #1 bus.sync = 1'b0;
        chk("sync_noenb_busy", bus.busy, 0);

        // Overrun and clear
        send_msb(4'h1, 0);
        send_msb(4'h2, 0);
        send_msb(4'h3, 0);
        exp_q.push_back(4'h1);
        exp_q.push_back(4'h2);
        chk("ovr_level", bus.level, 2);
        chk("ovr_set", bus.overrun, 1);
        pop_n(2);
        chk("ovr_drained", bus.valid, 0);
        chk("ovr_sticky", bus.overrun, 1);
        bus.clr_ovr = 1'b1; @(posedge clk); #1 bus.clr_ovr = 1'b0;
        chk("ovr_clr", bus.overrun, 0);

        // Full FIFO: push and pop on the same edge
        send_msb(4'hA, 0);
        send_msb(4'hB, 0);
        exp_q.push_back(4'hA);
        exp_q.push_back(4'hB);
        chk("full_level", bus.level, 2);
        exp_q.push_back(4'hC);
        send_msb(4'hC, 1);
        chk("full_pp_ovr", bus.overrun, 0);
        chk("full_pp_level", bus.level, 2);
        chk("full_pp_head", bus.q, 4'hB);
        pop_n(2);
        chk("full_pp_empty", bus.level, 0);

        // Reset mid-frame with a word buffered
        send_msb(4'h9, 0);
        send_bit(1, 0, 1);
        send_bit(1, 0, 0);
        send_bit(1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.valid, 0);
        chk("arst_q", bus.q, 0);
        chk("arst_level", bus.level, 0);
        chk("arst_busy", bus.busy, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        send_bit(0, 0, 0);
        send_bit(1, 0, 0);
        send_bit(1, 0, 0);
        send_bit(0, 0, 0);
        chk("arst_new_q", bus.q, 4'h6);
        chk("arst_new_level", bus.level, 1);
        exp_q.push_back(4'h6);
        pop_n(1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
